// File: rtl/guess_display.sv
// rtl/guess_display.sv - guess counter, double-dabble BCD engine and 4-digit muxed 7-segment driver
module guess_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic       done,
    input  logic       outrange,
    input  logic [7:0] LL,
    input  logic [7:0] HL,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [6:0] tries,
    output logic       busy
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] G_BLANK = 7'h7F;
    localparam logic [6:0] G_DASH  = 7'h3F;
    localparam logic [6:0] G_E     = 7'h06;
    localparam logic [6:0] G_R     = 7'h2F;
    localparam logic [6:0] G_D     = 7'h21;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    state_t      state;
    state_t      state_n;
    logic [2:0]  shcnt;
    logic [1:0]  sel;
    logic [11:0] acc;
    logic [7:0]  bin;
    logic [7:0]  src;
    logic [11:0] acc_adj;
    logic [11:0] ll_bcd;
    logic [11:0] hl_bcd;
    logic [11:0] tr_bcd;
    logic        valid;

    logic        enter_q;
    logic        rise;

    logic [CW-1:0] cnt;
    logic [1:0]    k;
    logic [1:0]    k_n;
    logic [6:0]    digit_seg;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    // Two-digit field: tens (hi=1) or ones of a BCD value, dashes when it overflows 99.
    function automatic logic [6:0] field(input logic [11:0] b, input logic hi);
        logic [6:0] g;
        if (b[11:8] != 4'd0)
            g = G_DASH;
        else if (hi)
            g = glyph(b[7:4]);
        else
            g = glyph(b[3:0]);
        return g;
    endfunction

    function automatic logic [11:0] dd_adjust(input logic [11:0] a);
        logic [11:0] r;
        r = a;
        for (int i = 0; i < 3; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Guess counter
    assign rise = enter & ~enter_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            enter_q <= 1'b0;
            tries   <= 7'd0;
        end else begin
            enter_q <= enter;
            if (rise && !done && tries != 7'd99)
                tries <= tries + 7'd1;
        end
    end

    // BCD engine FSM
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        case (state)
            IDLE:  state_n = LOAD;
            LOAD: begin
                busy    = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (shcnt == 3'd7)
                    state_n = STORE;
            end
            STORE: state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (sel)
            2'd0:    src = LL;
            2'd1:    src = HL;
            default: src = {1'b0, tries};
        endcase
    end

    assign acc_adj = dd_adjust(acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= 2'd0;
            acc    <= 12'd0;
            bin    <= 8'd0;
            shcnt  <= 3'd0;
            valid  <= 1'b0;
            ll_bcd <= 12'd0;
            hl_bcd <= 12'd0;
            tr_bcd <= 12'd0;
        end else begin
            case (state)
                LOAD: begin
                    bin   <= src;
                    acc   <= 12'd0;
                    shcnt <= 3'd0;
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[10:0], bin, 1'b0};
                    shcnt      <= shcnt + 3'd1;
                end
                STORE: begin
                    case (sel)
                        2'd0:    ll_bcd <= acc;
                        2'd1:    hl_bcd <= acc;
                        default: tr_bcd <= acc;
                    endcase
                    if (sel == 2'd2) begin
                        sel   <= 2'd0;
                        valid <= 1'b1;
                    end else begin
                        sel <= sel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan timing
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            k   <= 2'd0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            k   <= k_n;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign k_n = k + 2'd1;

    // Digit content selection, d3 is leftmost (k=3)
    always_comb begin
        digit_seg = G_BLANK;
        if (!valid) begin
            digit_seg = G_BLANK;
        end else if (done) begin
            case (k)
                2'd3:    digit_seg = G_D;
                2'd2:    digit_seg = G_BLANK;
                2'd1:    digit_seg = field(tr_bcd, 1'b1);
                default: digit_seg = field(tr_bcd, 1'b0);
            endcase
        end else if (outrange) begin
            case (k)
                2'd3:    digit_seg = G_BLANK;
                2'd2:    digit_seg = G_E;
                default: digit_seg = G_R;
            endcase
        end else begin
            case (k)
                2'd3:    digit_seg = field(ll_bcd, 1'b1);
                2'd2:    digit_seg = field(ll_bcd, 1'b0);
                2'd1:    digit_seg = field(hl_bcd, 1'b1);
                default: digit_seg = field(hl_bcd, 1'b0);
            endcase
        end
    end

    // seg and an share one register stage so they switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= G_BLANK;
        end else begin
            an  <= ~(4'b0001 << k);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_guess_display.sv
// tb/tb_guess_display.sv - randomized self-checking bench for guess_display
module tb_guess_display;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter;
    logic       done;
    logic       outrange;
    logic [7:0] LL;
    logic [7:0] HL;
    logic [6:0] seg;
    logic [3:0] an;
    logic [6:0] tries;
    logic       busy;

    int checks;
    int failures;
    int model_tries;

    logic [6:0] cap_seg [4];
    logic [3:0] cap_seen;

    guess_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .enter(enter), .done(done), .outrange(outrange),
        .LL(LL), .HL(HL), .seg(seg), .an(an), .tries(tries), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] dig_glyph(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Expected glyph at digit position pos (3 = leftmost) from the game rules.
    function automatic logic [6:0] exp_glyph(int pos, bit vld, bit dn, bit orng, int ll, int hl, int tr);
        int v;
        if (!vld) return 7'h7F;
        if (dn) begin
            if (pos == 3) return 7'h21;
            if (pos == 2) return 7'h7F;
            v = tr;
        end else if (orng) begin
            if (pos == 3) return 7'h7F;
            if (pos == 2) return 7'h06;
            return 7'h2F;
        end else begin
            v = (pos >= 2) ? ll : hl;
        end
        if (v >= 100) return 7'h3F;
        return (pos % 2 == 1) ? dig_glyph((v / 10) % 10) : dig_glyph(v % 10);
    endfunction

    function automatic int an_pos(logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << i;
            if (a == ~oh) return i;
        end
        return -1;
    endfunction

    // Record the glyph shown at each digit over slightly more than one scan round.
    task automatic capture();
        int p;
        cap_seen = 4'b0000;
        repeat (4 * SD + 2) begin
            tick();
            p = an_pos(an);
            if (p >= 0) begin
                cap_seg[p]  = seg;
                cap_seen[p] = 1'b1;
            end
        end
    endtask

    task automatic pulse();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        if (!done && model_tries < 99) model_tries++;
    endtask

    task automatic test_reset();
        int p;
        logic [6:0] e;
        enter = 0; done = 0; outrange = 0; LL = 8'd0; HL = 8'd0;
        rst = 1'b1;
        repeat (3) tick();
        model_tries = 0;
        checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an: got %b want 1110", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7f", seg); end
        checks++; if (tries !== 7'd0) begin failures++; $display("FAIL reset_tries: got %0d want 0", tries); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            tick();
            checks++;
            if (seg !== 7'h7F) begin failures++; $display("FAIL reset_blank: cycle %0d got %h want 7f", c, seg); end
        end
        tick();
        p = an_pos(an);
        e = exp_glyph(p, 1, 0, 0, 0, 0, 0);
        checks++;
        if (p < 0 || seg !== e) begin failures++; $display("FAIL first_valid: an=%b seg=%h want %h", an, seg, e); end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] oh;
        int k0;
        int n;
        prev = an;
        n = 0;
        while (an === prev && n < 2 * SD) begin
            tick();
            n++;
        end
        k0 = an_pos(an);
        checks++;
        if (k0 < 0) begin failures++; $display("FAIL scan_start: an=%b not one-hot low", an); end
        else begin
            for (int i = 0; i < 16; i++) begin
                oh = 4'b0001 << ((k0 + i / SD) % 4);
                checks++;
                if (an !== ~oh) begin failures++; $display("FAIL scan_order: step %0d got %b want %b", i, an, ~oh); end
                tick();
            end
        end
    endtask

    task automatic check_view(string name, bit dn, bit orng);
        logic [6:0] e;
        for (int i = 0; i < 4; i++) begin
            e = exp_glyph(i, 1, dn, orng, int'(LL), int'(HL), model_tries);
            checks++;
            if (!cap_seen[i] || cap_seg[i] !== e) begin
                failures++;
                $display("FAIL %s: d%0d got %h want %h (LL=%0d HL=%0d tries=%0d)", name, i, cap_seg[i], e, LL, HL, model_tries);
            end
        end
    endtask

    task automatic test_normal();
        LL = 8'd1; HL = 8'd99;
        repeat (45) tick();
        capture();
        check_view("normal_fixed", 0, 0);
        for (int r = 0; r < 5; r++) begin
            LL = 8'($urandom_range(0, 255));
            HL = 8'($urandom_range(0, 99));
            repeat (45) tick();
            capture();
            check_view("normal_rand", 0, 0);
        end
    endtask

    task automatic test_outrange();
        LL = 8'd42; HL = 8'd57;
        repeat (45) tick();
        outrange = 1'b1;
        tick();
        capture();
        check_view("outrange_on", 0, 1);
        outrange = 1'b0;
        tick();
        capture();
        check_view("outrange_off", 0, 0);
    endtask

    task automatic test_counter();
        rst = 1'b1; tick(); rst = 1'b0; model_tries = 0;
        enter = 1'b1;
        tick();
        checks++; if (tries !== 7'd1) begin failures++; $display("FAIL count_latency: got %0d want 1", tries); end
        enter = 1'b0; tick();
        model_tries = 1;
        repeat (4) pulse();
        enter = 1'b1;
        repeat (20) tick();
        enter = 1'b0;
        tick();
        model_tries++;
        checks++; if (tries !== 7'(model_tries) || model_tries != 6) begin failures++; $display("FAIL count_held: got %0d want 6", tries); end
        done = 1'b1;
        repeat (3) pulse();
        done = 1'b0;
        checks++; if (tries !== 7'(model_tries)) begin failures++; $display("FAIL count_done: got %0d want %0d", tries, model_tries); end
        repeat (100) pulse();
        checks++; if (tries !== 7'd99) begin failures++; $display("FAIL count_sat: got %0d want 99", tries); end
        pulse();
        checks++; if (tries !== 7'(model_tries)) begin failures++; $display("FAIL count_sat_hold: got %0d want %0d", tries, model_tries); end
    endtask

    task automatic test_won();
        rst = 1'b1; tick(); rst = 1'b0; model_tries = 0;
        LL = 8'd30; HL = 8'd40;
        repeat (7) pulse();
        done = 1'b1;
        repeat (50) tick();
        capture();
        check_view("won", 1, 0);
        done = 1'b0;
    endtask

    task automatic test_wide();
        HL = 8'd200; LL = 8'd7;
        repeat (45) tick();
        capture();
        check_view("wide_hl", 0, 0);
        HL = 8'd63; LL = 8'd150;
        repeat (45) tick();
        capture();
        check_view("wide_ll", 0, 0);
    endtask

    task automatic test_reset_abort();
        int n;
        int p;
        logic [6:0] e;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
        LL = 8'd88; HL = 8'd12;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_tries = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (seg !== 7'h7F || an !== 4'b1110) begin failures++; $display("FAIL abort_out: seg=%h an=%b want 7f 1110", seg, an); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_idle: got busy %b want 1 after one idle cycle", busy); end
        for (int c = 2; c <= 31; c++) begin
            tick();
            checks++;
            if (seg !== 7'h7F) begin failures++; $display("FAIL abort_blank: cycle %0d got %h want 7f", c, seg); end
        end
        tick();
        p = an_pos(an);
        e = exp_glyph(p, 1, 0, 0, int'(LL), int'(HL), 0);
        checks++;
        if (p < 0 || seg !== e) begin failures++; $display("FAIL abort_restart: an=%b seg=%h want %h", an, seg, e); end
        capture();
        check_view("abort_view", 0, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_tries = 0;
        rst = 1'b1; enter = 0; done = 0; outrange = 0; LL = 0; HL = 0;
        test_reset();
        test_scan();
        test_normal();
        test_outrange();
        test_counter();
        test_won();
        test_wide();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
